// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync/blank/strobe decode plus a
// pixel-replicating framebuffer address engine, all advanced by pix_en.
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int H_SHIFT  = 1,
  parameter int V_SHIFT  = 1,
  parameter int CW       = 11,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic [AW-1:0] fb_base,
  output logic          h_sync,
  output logic          v_sync,
  output logic          h_blank,
  output logic          v_blank,
  output logic          blank,
  output logic          frame_start,
  output logic          line_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [AW-1:0] addr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSW     = (H_SHIFT > 0) ? H_SHIFT : 1;
  localparam int VSW     = (V_SHIFT > 0) ? V_SHIFT : 1;

  // Compare constants carry one extra bit so a total of exactly 2^CW still fits.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] H_LAST     = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] V_LAST     = (CW+1)'(V_TOTAL - 1);

  // With a shift of 0 the max is 0, so the sub-counter sits at 0 and every step replicates once.
  localparam logic [HSW-1:0] H_SUB_MAX = HSW'((1 << H_SHIFT) - 1);
  localparam logic [VSW-1:0] V_SUB_MAX = VSW'((1 << V_SHIFT) - 1);
  localparam logic [AW-1:0]  STRIDE    = AW'(H_ACTIVE >> H_SHIFT);

  logic [CW-1:0]  h_cnt, v_cnt;
  logic [CW:0]    h_ext, v_ext;
  logic [AW-1:0]  line_base, src_addr, next_line;
  logic [HSW-1:0] h_sub;
  logic [VSW-1:0] v_sub;
  logic           h_act, v_act, h_in_sync, v_in_sync;
  logic           h_last, v_last, frame_end;

  assign h_ext     = {1'b0, h_cnt};
  assign v_ext     = {1'b0, v_cnt};
  assign h_act     = h_ext < H_ACT_END;
  assign v_act     = v_ext < V_ACT_END;
  assign h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
  assign v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
  assign h_last    = h_ext == H_LAST;
  assign v_last    = v_ext == V_LAST;
  assign frame_end = h_last && v_last;
  assign next_line = line_base + STRIDE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // fb_base is only looked at on the last pixel, so mid-frame changes wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      src_addr  <= '0;
      h_sub     <= '0;
      v_sub     <= '0;
    end else if (pix_en) begin
      if (frame_end) begin
        line_base <= fb_base;
        src_addr  <= fb_base;
        h_sub     <= '0;
        v_sub     <= '0;
      end else if (h_act && v_act) begin
        if (h_sub == H_SUB_MAX) begin
          h_sub    <= '0;
          src_addr <= src_addr + AW'(1);
        end else begin
          h_sub <= h_sub + HSW'(1);
        end
      end else if (h_last && v_act) begin
        h_sub <= '0;
        if (v_sub == V_SUB_MAX) begin
          v_sub     <= '0;
          line_base <= next_line;
          src_addr  <= next_line;
        end else begin
          v_sub    <= v_sub + VSW'(1);
          src_addr <= line_base;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      h_blank     <= 1'b1;
      v_blank     <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
    end else if (pix_en) begin
      h_sync      <= h_in_sync ? H_POL : ~H_POL;
      v_sync      <= v_in_sync ? V_POL : ~V_POL;
      h_blank     <= ~h_act;
      v_blank     <= ~v_act;
      blank       <= ~(h_act && v_act);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= h_cnt == '0;
      x           <= h_cnt;
      y           <= v_cnt;
      addr        <= src_addr;
    end
  end

endmodule
